// File: rtl/perips_intc.sv
// perips_intc: memory-mapped interrupt controller with per-source enable,
// level/rising-edge trigger selection and a claim/complete handshake.
// Optional feature macro: INTC_PRIORITY_EN adds 4-bit per-source priorities
// (0x14/0x18) and a priority threshold (0x1C).

`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 32
`endif

module perips_intc #(
    parameter int NUM_SRC = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [7:0]                 addr_i,
    input  logic                       data_rd_i,
    input  logic                       data_we_i,
    input  logic [`DATA_BUS_WIDTH-1:0] data_i,
    output logic [`DATA_BUS_WIDTH-1:0] data_o,
    input  logic [NUM_SRC-1:0]         irq_src_i,
    output logic                       irq_o
);

    localparam int DW = `DATA_BUS_WIDTH;

    localparam logic [7:0] ADDR_EN       = 8'h00;
    localparam logic [7:0] ADDR_PEND     = 8'h04;
    localparam logic [7:0] ADDR_TRIG     = 8'h08;
    localparam logic [7:0] ADDR_CLAIM    = 8'h0C;
    localparam logic [7:0] ADDR_COMPLETE = 8'h10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t               r_state;
    logic [4:0]           r_active_id;
    logic                 r_irq;
    logic [NUM_SRC-1:0]   r_en;
    logic [NUM_SRC-1:0]   r_trig;
    logic [NUM_SRC-1:0]   r_pend;
    logic [NUM_SRC-1:0]   r_src_q;
    logic [DW-1:0]        r_data;

    logic                 w_we_en;
    logic                 w_we_pend;
    logic                 w_we_trig;
    logic                 w_we_complete;
    logic                 w_rd_claim;
    logic [NUM_SRC-1:0]   w_req;
    logic [NUM_SRC-1:0]   w_pend_nxt;
    logic                 w_found;
    logic [4:0]           w_win_id;
    logic                 w_claim_take;
    logic                 w_complete_ok;
    logic [DW-1:0]        w_rd_data;
    logic                 w_unused;

    assign w_we_en       = data_we_i && (addr_i == ADDR_EN);
    assign w_we_pend     = data_we_i && (addr_i == ADDR_PEND);
    assign w_we_trig     = data_we_i && (addr_i == ADDR_TRIG);
    assign w_we_complete = data_we_i && (addr_i == ADDR_COMPLETE);
    assign w_rd_claim    = data_rd_i && (addr_i == ADDR_CLAIM);
    assign w_req         = r_en & r_pend;
    assign w_unused      = &{1'b0, data_i};

`ifdef INTC_PRIORITY_EN
    localparam logic [7:0] ADDR_PRIO0  = 8'h14;
    localparam logic [7:0] ADDR_PRIO1  = 8'h18;
    localparam logic [7:0] ADDR_THRESH = 8'h1C;

    // Only nibbles of implemented sources are storable; IDs above 16 have no
    // priority slot, so they read as priority 0 and never interrupt.
    function automatic logic [63:0] prio_mask();
        logic [63:0] m;
        m = '0;
        for (int n = 0; n < 16; n++) begin
            if (n < NUM_SRC) m[n*4 +: 4] = 4'hF;
        end
        return m;
    endfunction

    localparam logic [63:0] PRIO_MASK = prio_mask();

    logic [63:0] r_prio;
    logic [3:0]  r_thresh;
    logic [3:0]  w_prio [NUM_SRC];
    logic [3:0]  w_best;

    // Unpack the priority words into one nibble per source
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            w_prio[i] = (i < 16) ? r_prio[(i % 16)*4 +: 4] : 4'd0;
        end
    end

    // Priority and threshold registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_prio   <= '0;
            r_thresh <= '0;
        end else if (data_we_i) begin
            if (addr_i == ADDR_PRIO0)  r_prio[31:0]  <= data_i[31:0] & PRIO_MASK[31:0];
            if (addr_i == ADDR_PRIO1)  r_prio[63:32] <= data_i[31:0] & PRIO_MASK[63:32];
            if (addr_i == ADDR_THRESH) r_thresh      <= data_i[3:0];
        end
    end

    // Winner: strictly above threshold, highest priority, ties to lowest ID
    always_comb begin
        w_found  = 1'b0;
        w_win_id = '0;
        w_best   = r_thresh;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_req[i] && (w_prio[i] > w_best)) begin
                w_found  = 1'b1;
                w_win_id = 5'(i + 1);
                w_best   = w_prio[i];
            end
        end
    end
`else
    // Winner: lowest enabled pending ID (scan downward so the lowest sticks)
    always_comb begin
        w_found  = 1'b0;
        w_win_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_found  = 1'b1;
                w_win_id = 5'(i + 1);
            end
        end
    end
`endif

    assign w_claim_take  = w_rd_claim && (r_state == S_IDLE) && w_found;
    assign w_complete_ok = w_we_complete && (r_state == S_BUSY) && (data_i[4:0] == r_active_id);

    // Next pending: level bits mirror the line, edge bits latch with set over clear
    always_comb begin
        w_pend_nxt = r_pend;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_trig[i]) begin
                if (w_we_pend && data_i[i])                      w_pend_nxt[i] = 1'b0;
                if (w_claim_take && (w_win_id == 5'(i + 1)))     w_pend_nxt[i] = 1'b0;
                if (irq_src_i[i] && !r_src_q[i])                 w_pend_nxt[i] = 1'b1;
            end else begin
                w_pend_nxt[i] = irq_src_i[i];
            end
        end
    end

    // Read mux; CLAIM reports the view of the current state
    always_comb begin
        w_rd_data = '0;
        case (addr_i)
            ADDR_EN:     w_rd_data = DW'(r_en);
            ADDR_PEND:   w_rd_data = DW'(r_pend);
            ADDR_TRIG:   w_rd_data = DW'(r_trig);
            ADDR_CLAIM:  w_rd_data = (r_state == S_BUSY) ? DW'(r_active_id)
                                   : (w_found ? DW'(w_win_id) : '0);
`ifdef INTC_PRIORITY_EN
            ADDR_PRIO0:  w_rd_data = DW'(r_prio[31:0]);
            ADDR_PRIO1:  w_rd_data = DW'(r_prio[63:32]);
            ADDR_THRESH: w_rd_data = DW'(r_thresh);
`endif
            default:     w_rd_data = '0;
        endcase
    end

    // Delay the raw lines one cycle for edge detection
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_src_q <= '0;
        else          r_src_q <= irq_src_i;
    end

    // Enable and trigger-mode registers, masked to implemented sources
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_en   <= '0;
            r_trig <= '0;
        end else begin
            if (w_we_en)   r_en   <= data_i[NUM_SRC-1:0];
            if (w_we_trig) r_trig <= data_i[NUM_SRC-1:0];
        end
    end

    // Pending register, latched independently of the enables
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_pend <= '0;
        else          r_pend <= w_pend_nxt;
    end

    // Claim/complete FSM with the registered CPU interrupt
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= S_IDLE;
            r_active_id <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_irq <= (r_state == S_IDLE) && w_found;
            case (r_state)
                S_IDLE: begin
                    if (w_claim_take) begin
                        r_state     <= S_BUSY;
                        r_active_id <= w_win_id;
                    end
                end
                S_BUSY: begin
                    if (w_complete_ok) begin
                        r_state     <= S_IDLE;
                        r_active_id <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Read data register, updated only on a read strobe
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)       r_data <= '0;
        else if (data_rd_i) r_data <= w_rd_data;
    end

    assign data_o = r_data;
    assign irq_o  = r_irq;

endmodule

// File: tb/tb_perips_intc.sv
// tb_perips_intc: scenario tasks for perips_intc. Read expectations are
// queued when a read is issued and compared when data_o becomes valid.
// Builds with or without INTC_PRIORITY_EN.

module tb_perips_intc;

    localparam int NUM_SRC = 8;

    logic                clk = 1'b0;
    logic                rstN;
    logic [7:0]          addr;
    logic                rd;
    logic                we;
    logic [31:0]         wdata;
    logic [31:0]         dataO;
    logic [NUM_SRC-1:0]  irqSrc;
    logic                irqO;

    int                  vectorsApplied = 0;
    int                  miscompares = 0;
    logic [31:0]         expQ[$];
    string               tagQ[$];
    logic                rdQ = 1'b0;

    always #5 clk = ~clk;

    perips_intc #(.NUM_SRC(NUM_SRC)) dut (
        .clk_i     (clk),
        .rst_n_i   (rstN),
        .addr_i    (addr),
        .data_rd_i (rd),
        .data_we_i (we),
        .data_i    (wdata),
        .data_o    (dataO),
        .irq_src_i (irqSrc),
        .irq_o     (irqO)
    );

    // Remember which cycles carried a read so the data can be checked next
    always @(posedge clk) rdQ <= rd;

    // Scoreboard: pop the expected read value once data_o has been updated
    always @(negedge clk) begin
        if (rdQ) begin
            vectorsApplied++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_read: data_o=%08h with no expectation queued", dataO);
            end else begin
                logic [31:0] e;
                string       t;
                e = expQ.pop_front();
                t = tagQ.pop_front();
                if (dataO !== e) begin
                    miscompares++;
                    $display("[TB] FAIL %s: data_o=%08h expected %08h", t, dataO, e);
                end
            end
        end
    end

    // Abort guard in case the run stalls
    initial begin
        #200000;
        miscompares++;
        $display("[TB] FAIL watchdog: time %0t exceeded limit", $time);
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic writeReg(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; we = 1'b1; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic issueRead(input logic [7:0] a, input logic [31:0] exp, input string tag);
        @(negedge clk);
        addr = a; rd = 1'b1;
        expQ.push_back(exp);
        tagQ.push_back(tag);
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic programPrio();
`ifdef INTC_PRIORITY_EN
        writeReg(8'h14, 32'h1111_1111);
        writeReg(8'h18, 32'h1111_1111);
        writeReg(8'h1C, 32'h0);
`else
        idle(1);
`endif
    endtask

    // Reset holds outputs low even with active sources; all registers read 0
    task automatic test_reset();
        rstN = 1'b0; rd = 1'b0; we = 1'b0; addr = '0; wdata = '0; irqSrc = '0;
        idle(2);
        irqSrc = '1;
        idle(3);
        vectorsApplied++;
        if (dataO !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: data_o=%08h expected 00000000", dataO);
        end
        vectorsApplied++;
        if (irqO !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_irq: irq_o=%b expected 0", irqO);
        end
        irqSrc = '0;
        @(negedge clk);
        rstN = 1'b1;
        for (int a = 0; a <= 8'h20; a += 4) begin
            issueRead(8'(a), 32'h0, $sformatf("reset_read_%02h", a));
        end
        idle(1);
        vectorsApplied++;
        if (irqO !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_irq_after: irq_o=%b expected 0", irqO);
        end
        programPrio();
    endtask

    // Single-cycle edge on source 1, claimed and completed
    task automatic test_edge();
        writeReg(8'h00, 32'h1);
        writeReg(8'h08, 32'h1);
        @(negedge clk); irqSrc = 8'h01;
        @(negedge clk); irqSrc = 8'h00;
        vectorsApplied++;
        if (irqO !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL edge_irq_latency: irq_o=%b expected 0", irqO);
        end
        @(negedge clk);
        vectorsApplied++;
        if (irqO !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL edge_irq_set: irq_o=%b expected 1", irqO);
        end
        issueRead(8'h04, 32'h1, "edge_pend");
        issueRead(8'h0C, 32'h1, "edge_claim");
        @(negedge clk);
        vectorsApplied++;
        if (irqO !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL edge_irq_drop: irq_o=%b expected 0", irqO);
        end
        issueRead(8'h04, 32'h0, "edge_pend_cleared");
        writeReg(8'h10, 32'h1);
        idle(2);
        vectorsApplied++;
        if (irqO !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL edge_irq_after_complete: irq_o=%b expected 0", irqO);
        end
        issueRead(8'h0C, 32'h0, "edge_claim_none");
    endtask

    // Held level sources 2 and 3; completion while still high re-raises irq
    task automatic test_level();
        writeReg(8'h08, 32'h0);
        writeReg(8'h00, 32'h6);
        @(negedge clk); irqSrc = 8'h06;
        idle(2);
        vectorsApplied++;
        if (irqO !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL level_irq_set: irq_o=%b expected 1", irqO);
        end
        issueRead(8'h04, 32'h6, "level_pend");
        issueRead(8'h0C, 32'h2, "level_claim");
        idle(1);
        vectorsApplied++;
        if (irqO !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL level_irq_busy: irq_o=%b expected 0", irqO);
        end
        writeReg(8'h10, 32'h2);
        idle(1);
        vectorsApplied++;
        if (irqO !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL level_reassert: irq_o=%b expected 1", irqO);
        end
        issueRead(8'h0C, 32'h2, "level_reclaim");
    endtask

    // Mismatched COMPLETE IDs leave the controller busy on the active ID
    task automatic test_mismatch();
        writeReg(8'h10, 32'h2);
        writeReg(8'h00, 32'h7);
        writeReg(8'h08, 32'h1);
        @(negedge clk); irqSrc = 8'h07;
        @(negedge clk); irqSrc = 8'h06;
        idle(1);
        issueRead(8'h04, 32'h7, "mix_pend");
        issueRead(8'h0C, 32'h1, "mix_claim_lowest");
        writeReg(8'h10, 32'h3);
        issueRead(8'h0C, 32'h1, "busy_after_bad_complete3");
        issueRead(8'h04, 32'h6, "mix_pend_after_claim");
        writeReg(8'h10, 32'h2);
        issueRead(8'h0C, 32'h1, "busy_after_bad_complete2");
        writeReg(8'h10, 32'h1);
        issueRead(8'h0C, 32'h2, "next_winner");
        writeReg(8'h10, 32'h2);
    endtask

    // Edge set wins over a same-cycle W1C or claim clear; level bits ignore W1C
    task automatic test_back_to_back();
        @(negedge clk); irqSrc = 8'h00;
        idle(1);
        @(negedge clk); irqSrc = 8'h01;
        @(negedge clk); irqSrc = 8'h00;
        @(negedge clk); irqSrc = 8'h01; addr = 8'h04; we = 1'b1; wdata = 32'h1;
        @(negedge clk); irqSrc = 8'h00; we = 1'b0;
        issueRead(8'h04, 32'h1, "w1c_edge_race");
        writeReg(8'h04, 32'h1);
        issueRead(8'h04, 32'h0, "w1c_clear");
        @(negedge clk); irqSrc = 8'h02;
        idle(1);
        writeReg(8'h04, 32'hFFFF_FFFF);
        issueRead(8'h04, 32'h2, "w1c_level_ignored");
        @(negedge clk); irqSrc = 8'h03;
        @(negedge clk); irqSrc = 8'h02;
        @(negedge clk); irqSrc = 8'h03; addr = 8'h0C; rd = 1'b1;
        expQ.push_back(32'h1);
        tagQ.push_back("claim_edge_race_id");
        @(negedge clk); irqSrc = 8'h02; rd = 1'b0;
        issueRead(8'h04, 32'h3, "claim_edge_race_pend");
        writeReg(8'h10, 32'h1);
    endtask

    // Enable gates only the request; upper data bits are dropped
    task automatic test_enable_mask();
        writeReg(8'h04, 32'h1);
        writeReg(8'h00, 32'h0);
        idle(2);
        vectorsApplied++;
        if (irqO !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL en_masked_irq: irq_o=%b expected 0", irqO);
        end
        issueRead(8'h04, 32'h2, "pend_without_en");
        issueRead(8'h0C, 32'h0, "claim_masked");
        writeReg(8'h00, 32'hFFFF_FFFF);
        issueRead(8'h00, 32'hFF, "en_upper_bits");
        writeReg(8'h08, 32'hFFFF_FF00);
        issueRead(8'h08, 32'h0, "trig_upper_bits");
        idle(1);
        vectorsApplied++;
        if (irqO !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL en_unmask_irq: irq_o=%b expected 1", irqO);
        end
    endtask

    // Read and write strobes in the same cycle act independently
    task automatic test_simultaneous();
        issueRead(8'h0C, 32'h2, "rw_claim");
        @(negedge clk); addr = 8'h10; rd = 1'b1; we = 1'b1; wdata = 32'h2;
        expQ.push_back(32'h0);
        tagQ.push_back("rw_complete_read");
        @(negedge clk); rd = 1'b0; we = 1'b0;
        issueRead(8'h0C, 32'h2, "claim_after_rw_complete");
        writeReg(8'h10, 32'h2);
        @(negedge clk); addr = 8'h00; rd = 1'b1; we = 1'b1; wdata = 32'h6;
        expQ.push_back(32'hFF);
        tagQ.push_back("rw_en_old");
        @(negedge clk); rd = 1'b0; we = 1'b0;
        issueRead(8'h00, 32'h6, "rw_en_new");
    endtask

`ifdef INTC_PRIORITY_EN
    // Highest priority above threshold wins; raising the threshold masks it
    task automatic test_priority();
        writeReg(8'h08, 32'h0);
        @(negedge clk); irqSrc = 8'h05;
        writeReg(8'h00, 32'h5);
        writeReg(8'h14, 32'h1111_1512);
        writeReg(8'h1C, 32'h4);
        idle(2);
        issueRead(8'h14, 32'h1111_1512, "prio_readback");
        issueRead(8'h0C, 32'h3, "prio_claim");
        writeReg(8'h10, 32'h3);
        writeReg(8'h1C, 32'h5);
        idle(2);
        vectorsApplied++;
        if (irqO !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL thresh_irq: irq_o=%b expected 0", irqO);
        end
        issueRead(8'h0C, 32'h0, "thresh_claim");
        issueRead(8'h1C, 32'h5, "thresh_readback");
        writeReg(8'h1C, 32'h0);
        writeReg(8'h14, 32'h1111_1111);
    endtask
`else
    // Priority window is inert without the feature
    task automatic test_priority();
        writeReg(8'h14, 32'hFFFF_FFFF);
        writeReg(8'h18, 32'hFFFF_FFFF);
        writeReg(8'h1C, 32'hFFFF_FFFF);
        issueRead(8'h14, 32'h0, "prio0_absent");
        issueRead(8'h18, 32'h0, "prio1_absent");
        issueRead(8'h1C, 32'h0, "thresh_absent");
        issueRead(8'h10, 32'h0, "complete_wo");
        issueRead(8'h24, 32'h0, "unmapped");
        issueRead(8'h00, 32'h6, "en_untouched");
    endtask
`endif

    // Reset in the middle of service returns everything to idle
    task automatic test_reset_mid();
        @(negedge clk); irqSrc = 8'h02;
        writeReg(8'h08, 32'h0);
        writeReg(8'h00, 32'h2);
        idle(1);
        issueRead(8'h0C, 32'h2, "pre_reset_claim");
        @(negedge clk); rstN = 1'b0; irqSrc = 8'h00;
        @(negedge clk);
        vectorsApplied++;
        if (dataO !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_data: data_o=%08h expected 00000000", dataO);
        end
        vectorsApplied++;
        if (irqO !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_irq: irq_o=%b expected 0", irqO);
        end
        @(negedge clk); rstN = 1'b1;
        programPrio();
        issueRead(8'h00, 32'h0, "reset_mid_en");
        issueRead(8'h0C, 32'h0, "reset_mid_claim");
        writeReg(8'h00, 32'h1);
        @(negedge clk); irqSrc = 8'h01;
        idle(2);
        issueRead(8'h0C, 32'h1, "reset_mid_idle_state");
    endtask

    initial begin
        test_reset();
        test_edge();
        test_level();
        test_mismatch();
        test_back_to_back();
        test_enable_mask();
        test_simultaneous();
        test_priority();
        test_reset_mid();
        idle(3);
        vectorsApplied++;
        if (expQ.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: %0d reads outstanding, expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
